// File: rtl/bcd_countdown_timer.sv
// Parametrised BCD mm:ss countdown timer with prescaler, start/stop/pause FSM and serial nibble load.
// Optional feature: define AUTO_RELOAD_EN to reload the start value on expiry and keep running.
module bcd_countdown_timer #(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 1
) (
  input  logic                    clock,
  input  logic                    clr,
  input  logic [3:0]              data,
  input  logic                    loadn,
  input  logic                    enable,
  input  logic                    start,
  input  logic                    stop,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    zero,
  output logic                    done,
  output logic                    running,
  output logic [1:0]              state
);

  localparam int MW = 4 * MIN_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t        cur_state, nxt_state;
  logic [PW-1:0] presc, presc_nxt;
  logic [3:0]    ones_nxt, tens_nxt;
  logic [MW-1:0] mins_nxt;
  logic          done_nxt;
  logic [3:0]    dec_ones, dec_tens;
  logic [MW-1:0] dec_mins;
  logic          dec_zero;

`ifdef AUTO_RELOAD_EN
  logic [MW+7:0] reload, reload_nxt;
`endif

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign zero  = (sec_ones == 4'd0) && (sec_tens == 4'd0) && (mins == '0);
  assign state = cur_state;

  // One-second BCD decrement with borrow rippling from the units upward
  always_comb begin
    logic borrow;
    borrow   = (sec_ones == 4'd0);
    dec_ones = borrow ? 4'd9 : sec_ones - 4'd1;
    dec_tens = sec_tens;
    if (borrow) begin
      dec_tens = (sec_tens == 4'd0) ? 4'd5 : sec_tens - 4'd1;
      borrow   = (sec_tens == 4'd0);
    end
    dec_mins = mins;
    for (int unsigned k = 0; k < MIN_DIGITS; k++) begin
      if (borrow) begin
        dec_mins[4*k +: 4] = (mins[4*k +: 4] == 4'd0) ? 4'd9 : mins[4*k +: 4] - 4'd1;
        borrow             = (mins[4*k +: 4] == 4'd0);
      end
    end
    dec_zero = (dec_ones == 4'd0) && (dec_tens == 4'd0) && (dec_mins == '0);
  end

  always_comb begin
    nxt_state = cur_state;
    presc_nxt = presc;
    ones_nxt  = sec_ones;
    tens_nxt  = sec_tens;
    mins_nxt  = mins;
    done_nxt  = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_nxt = reload;
`endif
    if (!loadn && cur_state != RUNNING) begin
      ones_nxt = clamp(data, 4'd9);
      tens_nxt = clamp(sec_ones, 4'd5);
      mins_nxt[3:0] = clamp(sec_tens, 4'd9);
      for (int unsigned k = 1; k < MIN_DIGITS; k++)
        mins_nxt[4*k +: 4] = clamp(mins[4*(k-1) +: 4], 4'd9);
      presc_nxt = '0;
      if (cur_state == EXPIRED)
        nxt_state = IDLE;
    end else begin
      case (cur_state)
        IDLE: begin
          if (!stop && start && !zero) begin
            nxt_state = RUNNING;
            presc_nxt = '0;
`ifdef AUTO_RELOAD_EN
            reload_nxt = {mins, sec_tens, sec_ones};
`endif
          end
        end
        RUNNING: begin
          if (stop) begin
            nxt_state = PAUSED;
          end else if (enable) begin
            if (presc == PRESC_LAST) begin
              presc_nxt = '0;
              if (!zero) begin
                ones_nxt = dec_ones;
                tens_nxt = dec_tens;
                mins_nxt = dec_mins;
                if (dec_zero) begin
                  done_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
                  {mins_nxt, tens_nxt, ones_nxt} = reload;
`else
                  nxt_state = EXPIRED;
`endif
                end
              end
            end else begin
              presc_nxt = presc + PW'(1);
            end
          end
        end
        PAUSED: begin
          if (!stop && start)
            nxt_state = RUNNING;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      cur_state <= IDLE;
      presc     <= '0;
      sec_ones  <= '0;
      sec_tens  <= '0;
      mins      <= '0;
      done      <= 1'b0;
      running   <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload    <= '0;
`endif
    end else begin
      cur_state <= nxt_state;
      presc     <= presc_nxt;
      sec_ones  <= ones_nxt;
      sec_tens  <= tens_nxt;
      mins      <= mins_nxt;
      done      <= done_nxt;
      running   <= (nxt_state == RUNNING);
`ifdef AUTO_RELOAD_EN
      reload    <= reload_nxt;
`endif
    end
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Parametrised BCD mm:ss countdown timer; successor to the fixed 1-digit-minute timer chain. Adds configurable minute-digit count, a tick prescaler, a start/stop/pause control FSM, a one-cycle expiry pulse and optional auto-reload. Digits are loaded by serial nibble shift. The block drives kitchen/lab timer display and alarm logic.

Parameters:
MIN_DIGITS, 2, number of BCD minute digits (1..4); max count (10^MIN_DIGITS - 1):59.
TICK_DIV, 1, enabled clock cycles per one-second decrement (>=1); 1 = decrement on every enabled RUNNING cycle.

Ports:
clock  in  1  system clock, rising edge.
clr  in  1  synchronous reset, active-high.
data  in  4  BCD nibble shifted into sec_ones during load.
loadn  in  1  active-low load/shift strobe.
enable  in  1  tick qualifier; prescaler and count advance only when high.
start  in  1  level-sampled start/resume request.
stop  in  1  level-sampled pause request.
sec_ones  out  4  seconds units digit (0..9).
sec_tens  out  4  seconds tens digit (0..5).
mins  out  4*MIN_DIGITS  minute digits; nibble 0 = units.
zero  out  1  combinational: all digits equal 0.
done  out  1  one-cycle pulse on expiry.
running  out  1  high in RUNNING.
state  out  2  IDLE=0, RUNNING=1, PAUSED=2, EXPIRED=3.

Behaviour:
- Reset (clr=1): all digits 0, state IDLE, prescaler 0, done 0, running 0. clr overrides all other inputs.
- All registers update on rising clock edge. Outputs are registered except zero.
- Load (loadn=0, state IDLE, PAUSED or EXPIRED), one shift per cycle: sec_ones<=min(data,9); sec_tens<=min(sec_ones,5); mins[3:0]<=sec_ones_old-chain... exactly: each mins nibble k takes nibble k-1 (nibble 0 takes sec_tens), clamped to 9. The top nibble is discarded. Load from EXPIRED moves the state to IDLE; load also clears the prescaler. loadn=0 in RUNNING is ignored.
- Priority per cycle: clr > loadn > stop > start > tick.
- IDLE: start=1 and zero=0 -> RUNNING, prescaler cleared. start with zero=1 -> stays IDLE.
- RUNNING: stop=1 -> PAUSED; the prescaler value is held. Otherwise, if enable=1: when prescaler==TICK_DIV-1, prescaler<=0 and the count decrements by one second; else prescaler+1. enable=0 freezes both.
- Decrement is BCD with borrow: sec_ones 0->9 with borrow; sec_tens 0->5 with borrow; each mins nibble 0->9 with borrow. No decrement is issued from 00:00.
- Expiry: the decrement whose result is all-zero registers 00:00, sets done=1 for exactly that cycle, and moves the state to EXPIRED in the same edge.
- PAUSED: start=1 (stop=0) -> RUNNING, prescaler resumes from the held value. Load is allowed.
- EXPIRED: digits hold 0; start is ignored; load or clr leaves the state.
- running = (state==RUNNING). done is never high outside the expiry cycle.
- Mid-operation clr returns to the reset values on the next edge; no done pulse.

Optional Feature:
AUTO_RELOAD_EN: a reload register captures all digits on the IDLE->RUNNING transition. On expiry, done pulses and the digits load the reload value in the same edge. The state stays RUNNING and the prescaler restarts at 0. A captured value of 0 is impossible because start requires zero=0. Without AUTO_RELOAD_EN, the reload register is absent and expiry goes to EXPIRED as above.

Test Plan:
- Reset: assert clr for 2 cycles mid-count -> all digits 0, state=0, done=0, zero=1.
- Load 01:05 (MIN_DIGITS=2): shift data 0,1,0,5 with loadn=0 -> mins=8'h01, sec_tens=0, sec_ones=5. Shifting 7 then 7 -> sec_tens=5 (clamp).
- Countdown (TICK_DIV=1, enable=1): load 01:05, pulse start -> after 1 cycle 01:04; 5 more ticks -> 00:59 (tens/mins borrow); the 65th tick -> 00:00 with done=1 for one cycle, state=3, and the count stays 0 afterwards.
- Prescaler/pause (TICK_DIV=4): load 00:03, start -> decrement every 4 enabled cycles. Hold enable low 3 cycles -> no change. Assert stop after 2 prescaler counts, resume with start -> the next decrement comes after 2 more enabled cycles.
- Priority: loadn=0 with start=1 in IDLE -> shift only, state stays IDLE. start+stop together in RUNNING -> PAUSED. start with zero=1 -> stays IDLE.
- AUTO_RELOAD_EN: load 00:02, start -> done pulses every 2 ticks, the count returns to 00:02, and running stays 1.
